rx_frame_buffer: RTL

Parametrised receive-side deframer and buffer that sits between the demodulator's bit stream (bitout/bitsinc) and the processor data port. It hunts for a configurable sync word and reads a length field. It assembles DATA_W-bit payload words MSB-first and queues them in a DEPTH-entry FIFO. A maskable interrupt is raised on FIFO threshold, frame completion or overflow. It replaces the fixed 8-bit, single-word, unbuffered receive path.

---
 rtl/rx_pkg.sv | 22 ++
 rtl/rx_sync_fifo.sv | 86 ++++++++
 rtl/rx_frame_buffer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg
// Shared definitions for the receive deframer/buffer slice.
//   rx_state_e      : deframer state (hunt for sync, read length, read payload)
//   RX_DEFAULT_SYNC : default sync pattern
//   IRQ_*_BIT       : bit positions inside the irq_mask vector
// ---------------------------------------------------------------------------
package rx_pkg;

    typedef enum logic [1:0] {
        RX_HUNT    = 2'd0,
        RX_LEN     = 2'd1,
        RX_PAYLOAD = 2'd2
    } rx_state_e;

    localparam logic [7:0] RX_DEFAULT_SYNC = 8'hA5;

    localparam int unsigned IRQ_THRESH_BIT = 0;
    localparam int unsigned IRQ_FRAME_BIT  = 1;
    localparam int unsigned IRQ_OVF_BIT    = 2;

endpackage

// File: rtl/rx_sync_fifo.sv
// ---------------------------------------------------------------------------
// rx_sync_fifo
// Single-clock first-word fall-through FIFO.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset (pointers and level cleared)
//   push_i   : write data_i; taken when not full or when a pop happens too
//   data_i   : write data
//   pop_i    : advance head; ignored when empty
//   data_o   : current head, 0 when empty
//   empty_o  : no entries
//   full_o   : DEPTH entries
//   level_o  : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module rx_sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q,  level_d;

    logic do_push;
    logic do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; data_o is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/rx_frame_buffer.sv
// ---------------------------------------------------------------------------
// rx_frame_buffer
// Receive deframer and buffer: hunts for SYNC_WORD in the demodulated bit
// stream, reads a DATA_W-bit length, assembles that many DATA_W-bit payload
// words MSB-first and queues them in a DEPTH-entry FIFO.
//   G_CLK_RX   : receive clock, rising edge
//   reset      : asynchronous active-low reset
//   bitin      : demodulated bit, valid with bitsinc
//   bitsinc    : one-cycle strobe per received bit
//   rd_en      : pop FIFO head (ignored when empty)
//   DATA_OUT   : FIFO head, fall-through, 0 when empty
//   empty/full : FIFO status
//   level      : FIFO occupancy
//   irq_thresh : level threshold, 0 disables that source
//   irq_mask   : [0] threshold, [1] frame done, [2] overflow
//   irq_clear  : clears sticky frame and overflow flags
//   interrupt  : registered OR of enabled sources
//   frame_done : one-cycle pulse at end of each frame
//   overflow   : sticky, payload word dropped on full FIFO
//   in_frame   : high while reading length or payload
// ---------------------------------------------------------------------------
module rx_frame_buffer
    import rx_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       DEPTH     = 16,
    parameter int unsigned       SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = RX_DEFAULT_SYNC
) (
    input  logic                   G_CLK_RX,
    input  logic                   reset,
    input  logic                   bitin,
    input  logic                   bitsinc,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      DATA_OUT,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    input  logic [$clog2(DEPTH):0] irq_thresh,
    input  logic [2:0]             irq_mask,
    input  logic                   irq_clear,
    output logic                   interrupt,
    output logic                   frame_done,
    output logic                   overflow,
    output logic                   in_frame
);

    localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_e         state_q,      state_d;
    logic [SYNC_W-1:0] sr_q,         sr_d;
    logic [CW-1:0]     bitcnt_q,     bitcnt_d;
    logic [DATA_W-1:0] word_q,       word_d;
    logic [DATA_W-1:0] remain_q,     remain_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_flag_q, frame_flag_d;
    logic              ovf_q,        ovf_d;
    logic              irq_q,        irq_d;

    logic [SYNC_W-1:0] sr_shift;
    logic [DATA_W-1:0] word_shift;
    logic              last_bit;
    logic              push;
    logic              frame_end;
    logic              drop;
    logic              thresh_hit;

    logic              fifo_full;
    logic              fifo_empty;
    logic [$clog2(DEPTH):0] fifo_level;

    assign sr_shift   = {sr_q[SYNC_W-2:0], bitin};
    assign word_shift = {word_q[DATA_W-2:0], bitin};
    assign last_bit   = (bitcnt_q == CW'(DATA_W - 1));

    // Deframer
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bitcnt_d  = bitcnt_q;
        word_d    = word_q;
        remain_d  = remain_q;
        push      = 1'b0;
        frame_end = 1'b0;
        if (bitsinc) begin
            case (state_q)
                RX_HUNT: begin
                    sr_d = sr_shift;
                    if (sr_shift == SYNC_WORD) begin
                        state_d  = RX_LEN;
                        bitcnt_d = '0;
                    end
                end
                RX_LEN: begin
                    word_d   = word_shift;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (last_bit) begin
                        bitcnt_d = '0;
                        if (word_shift == '0) begin
                            frame_end = 1'b1;
                            state_d   = RX_HUNT;
                            sr_d      = '0;
                        end else begin
                            remain_d = word_shift;
                            state_d  = RX_PAYLOAD;
                        end
                    end
                end
                RX_PAYLOAD: begin
                    word_d   = word_shift;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (last_bit) begin
                        bitcnt_d = '0;
                        push     = 1'b1;
                        remain_d = remain_q - 1'b1;
                        if (remain_q == DATA_W'(1)) begin
                            frame_end = 1'b1;
                            state_d   = RX_HUNT;
                            sr_d      = '0;
                        end
                    end
                end
                default: begin
                    state_d = RX_HUNT;
                    sr_d    = '0;
                end
            endcase
        end
    end

    // A full FIFO only accepts a push when a pop frees the head this cycle.
    assign drop = push && fifo_full && !rd_en;

    assign thresh_hit = irq_mask[IRQ_THRESH_BIT] && (irq_thresh != '0) &&
                        (fifo_level >= irq_thresh);

    // Sticky flags: a set in the same cycle as irq_clear wins.
    always_comb begin
        frame_done_d = frame_end;
        frame_flag_d = frame_end ? 1'b1 : (irq_clear ? 1'b0 : frame_flag_q);
        ovf_d        = drop      ? 1'b1 : (irq_clear ? 1'b0 : ovf_q);
        irq_d        = thresh_hit ||
                       (irq_mask[IRQ_FRAME_BIT] && frame_flag_q) ||
                       (irq_mask[IRQ_OVF_BIT]   && ovf_q);
    end

    always_ff @(posedge G_CLK_RX or negedge reset) begin
        if (!reset) begin
            state_q      <= RX_HUNT;
            sr_q         <= '0;
            bitcnt_q     <= '0;
            word_q       <= '0;
            remain_q     <= '0;
            frame_done_q <= 1'b0;
            frame_flag_q <= 1'b0;
            ovf_q        <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bitcnt_q     <= bitcnt_d;
            word_q       <= word_d;
            remain_q     <= remain_d;
            frame_done_q <= frame_done_d;
            frame_flag_q <= frame_flag_d;
            ovf_q        <= ovf_d;
            irq_q        <= irq_d;
        end
    end

    rx_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (G_CLK_RX),
        .rst_ni  (reset),
        .push_i  (push),
        .data_i  (word_shift),
        .pop_i   (rd_en),
        .data_o  (DATA_OUT),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    assign empty      = fifo_empty;
    assign full       = fifo_full;
    assign level      = fifo_level;
    assign interrupt  = irq_q;
    assign frame_done = frame_done_q;
    assign overflow   = ovf_q;
    assign in_frame   = (state_q != RX_HUNT);

endmodule
